// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: bundles the two requester ports, the shared read
// result and the dual-port RAM connection of ram_port_arbiter.
//   slave  : the arbiter's view (drives grants, rvalids, rdata, RAM controls)
//   master : the environment's view (requesters plus the RAM, which returns
//            ram_data_out)
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  // Requester A
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  // Requester B
  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  // Shared read result
  logic [DATA_WIDTH-1:0] rdata;
  // RAM side
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_write_addr;
  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata,
    output ram_we, ram_write_addr, ram_read_addr, ram_data_in,
    input  ram_data_out
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata,
    input  ram_we, ram_write_addr, ram_read_addr, ram_data_in,
    output ram_data_out
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one write port and one registered read port of a
// dual-port RAM between requesters A and B. Each port has its own
// round-robin arbiter, so a write and a read can issue in the same cycle.
// Grants are combinational (zero arbitration latency); the read winner is
// tagged so the RAM data returned one cycle later is steered to it.
//
// Optional feature: define RAM_PORT_ARBITER_BYPASS_EN to forward write data
// to the read result when a read and a write to the same address issue in
// the same cycle. Without it the read returns the pre-write word.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);

  // Requester identity; also the encoding of the last-granted pointers
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // Requesters gathered into indexable form (index 0 = A, 1 = B)
  logic [1:0]            req_vec;
  logic [1:0]            we_vec;
  logic [ADDR_WIDTH-1:0] addr_vec  [2];
  logic [DATA_WIDTH-1:0] wdata_vec [2];

  // Per-port eligibility and grants
  logic [1:0] wr_elig;
  logic [1:0] rd_elig;
  logic [1:0] wr_gnt;
  logic [1:0] rd_gnt;
  logic       wr_any;
  logic       rd_any;
  req_id_t    wr_win;
  req_id_t    rd_win;

  // Muxed RAM-side values
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Arbitration pointers and read-return tracking
  req_id_t wr_last_reg;
  req_id_t wr_last_next;
  req_id_t rd_last_reg;
  req_id_t rd_last_next;
  req_id_t rd_tag_reg;
  req_id_t rd_tag_next;
  logic    rd_pend_reg;
  logic    rd_pend_next;

  assign req_vec      = {bus.b_req, bus.a_req};
  assign we_vec       = {bus.b_we, bus.a_we};
  assign addr_vec[0]  = bus.a_addr;
  assign addr_vec[1]  = bus.b_addr;
  assign wdata_vec[0] = bus.a_wdata;
  assign wdata_vec[1] = bus.b_wdata;

  // Per-requester eligibility and round-robin grant on each port. When both
  // requesters want the same port, the one not named by that port's
  // last-granted pointer wins. Nothing is granted during reset.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      localparam req_id_t SELF_ID = (gi == 0) ? REQ_A : REQ_B;
      localparam int      OTHER   = 1 - gi;

      assign wr_elig[gi] = req_vec[gi] & we_vec[gi];
      assign rd_elig[gi] = req_vec[gi] & ~we_vec[gi];

      assign wr_gnt[gi] = ~rst & wr_elig[gi] &
                          (~wr_elig[OTHER] | (wr_last_reg != SELF_ID));
      assign rd_gnt[gi] = ~rst & rd_elig[gi] &
                          (~rd_elig[OTHER] | (rd_last_reg != SELF_ID));
    end
  endgenerate

  assign wr_any = |wr_gnt;
  assign rd_any = |rd_gnt;
  assign wr_win = wr_gnt[1] ? REQ_B : REQ_A;
  assign rd_win = rd_gnt[1] ? REQ_B : REQ_A;

  // RAM port muxing; idle ports present all-zero address/data
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    if (wr_any) begin
      wr_addr = (wr_win == REQ_B) ? addr_vec[1]  : addr_vec[0];
      wr_data = (wr_win == REQ_B) ? wdata_vec[1] : wdata_vec[0];
    end
    if (rd_any) begin
      rd_addr = (rd_win == REQ_B) ? addr_vec[1] : addr_vec[0];
    end
  end

  assign bus.ram_we         = wr_any;
  assign bus.ram_write_addr = wr_addr;
  assign bus.ram_data_in    = wr_data;
  assign bus.ram_read_addr  = rd_addr;

  // A requester has a single outstanding access type, so at most one of its
  // two grants can be set in a cycle.
  assign bus.a_gnt = wr_gnt[0] | rd_gnt[0];
  assign bus.b_gnt = wr_gnt[1] | rd_gnt[1];

  // Read return is steered by the tag captured in the grant cycle
  assign bus.a_rvalid = rd_pend_reg & (rd_tag_reg == REQ_A);
  assign bus.b_rvalid = rd_pend_reg & (rd_tag_reg == REQ_B);

  // Next-state for pointers and read tracking: pointers follow the winner,
  // and hold when their port is idle
  always_comb begin
    wr_last_next = wr_last_reg;
    rd_last_next = rd_last_reg;
    rd_tag_next  = rd_tag_reg;
    rd_pend_next = rd_any;
    if (wr_any) begin
      wr_last_next = wr_win;
    end
    if (rd_any) begin
      rd_last_next = rd_win;
      rd_tag_next  = rd_win;
    end
  end

  // State registers; reset points both arbiters at B so A goes first
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_last_reg <= REQ_B;
      rd_last_reg <= REQ_B;
      rd_tag_reg  <= REQ_A;
      rd_pend_reg <= 1'b0;
    end else begin
      wr_last_reg <= wr_last_next;
      rd_last_reg <= rd_last_next;
      rd_tag_reg  <= rd_tag_next;
      rd_pend_reg <= rd_pend_next;
    end
  end

`ifdef RAM_PORT_ARBITER_BYPASS_EN
  logic                  byp_hit_reg;
  logic                  byp_hit_next;
  logic [DATA_WIDTH-1:0] byp_data_reg;
  logic [DATA_WIDTH-1:0] byp_data_next;

  // Detect a same-cycle read and write to one address; keep the new word
  always_comb begin
    byp_hit_next  = wr_any & rd_any & (wr_addr == rd_addr);
    byp_data_next = wr_data;
  end

  // Forwarding registers, aligned with the RAM's registered read
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit_reg  <= 1'b0;
      byp_data_reg <= '0;
    end else begin
      byp_hit_reg  <= byp_hit_next;
      byp_data_reg <= byp_data_next;
    end
  end

  assign bus.rdata = byp_hit_reg ? byp_data_reg : bus.ram_data_out;
`else
  assign bus.rdata = bus.ram_data_out;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model of the
// two round-robin ports and the RAM contents. The bench owns the RAM.
// Honours RAM_PORT_ARBITER_BYPASS_EN for the collision result.
module tb_ram_port_arbiter;

  logic clk;
  logic rst;

  ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port RAM: one write port, registered read returning the old word
  logic [7:0] ram_mem [16];
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_write_addr] <= bus.ram_data_in;
    bus.ram_data_out <= ram_mem[bus.ram_read_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int m_mem   [16];
  bit m_known [16];
  int m_wr_last = 1;   // 0 = A, 1 = B
  int m_rd_last = 1;
  bit m_pend = 1'b0;
  int m_pend_id = 0;
  int m_pend_data = 0;
  bit m_pend_known = 1'b0;

  // Model and per-cycle comparison
  always @(negedge clk) begin : model_cmp
    int rq [2];
    int wv [2];
    int ad [2];
    int wd [2];
    int wwin, rwin, nwr, nrd;
    int e_waddr, e_wdata, e_raddr;
    int nd_data;
    bit nd_known;
    rq[0] = int'(bus.a_req);  rq[1] = int'(bus.b_req);
    wv[0] = int'(bus.a_we);   wv[1] = int'(bus.b_we);
    ad[0] = int'(bus.a_addr); ad[1] = int'(bus.b_addr);
    wd[0] = int'(bus.a_wdata); wd[1] = int'(bus.b_wdata);
    wwin = -1;
    rwin = -1;
    if (!rst) begin
      nwr = 0;
      nrd = 0;
      for (int i = 0; i < 2; i++) begin
        if (rq[i] != 0 && wv[i] != 0) nwr++;
        if (rq[i] != 0 && wv[i] == 0) nrd++;
      end
      if (nwr == 2) wwin = 1 - m_wr_last;
      else for (int i = 0; i < 2; i++) if (rq[i] != 0 && wv[i] != 0) wwin = i;
      if (nrd == 2) rwin = 1 - m_rd_last;
      else for (int i = 0; i < 2; i++) if (rq[i] != 0 && wv[i] == 0) rwin = i;
    end
    e_waddr = 0; e_wdata = 0; e_raddr = 0;
    if (wwin >= 0) begin e_waddr = ad[wwin]; e_wdata = wd[wwin]; end
    if (rwin >= 0) e_raddr = ad[rwin];

    chk("a_gnt", int'(bus.a_gnt), int'(wwin == 0 || rwin == 0));
    chk("b_gnt", int'(bus.b_gnt), int'(wwin == 1 || rwin == 1));
    chk("ram_we", int'(bus.ram_we), int'(wwin >= 0));
    chk("ram_write_addr", int'(bus.ram_write_addr), e_waddr);
    chk("ram_data_in", int'(bus.ram_data_in), e_wdata);
    chk("ram_read_addr", int'(bus.ram_read_addr), e_raddr);
    chk("a_rvalid", int'(bus.a_rvalid), int'(m_pend && m_pend_id == 0));
    chk("b_rvalid", int'(bus.b_rvalid), int'(m_pend && m_pend_id == 1));
    if (m_pend && m_pend_known) chk("rdata", int'(bus.rdata), m_pend_data);

    // Advance the model across the coming edge
    nd_data = 0;
    nd_known = 1'b0;
    if (rwin >= 0) begin
      nd_data = m_mem[e_raddr];
      nd_known = m_known[e_raddr];
`ifdef RAM_PORT_ARBITER_BYPASS_EN
      if (wwin >= 0 && e_waddr == e_raddr) begin
        nd_data = e_wdata;
        nd_known = 1'b1;
      end
`endif
    end
    m_pend = (rwin >= 0);
    m_pend_id = (rwin >= 0) ? rwin : m_pend_id;
    m_pend_data = nd_data;
    m_pend_known = nd_known;
    if (wwin >= 0) begin
      m_mem[e_waddr] = e_wdata;
      m_known[e_waddr] = 1'b1;
    end
    if (rst) begin
      m_wr_last = 1;
      m_rd_last = 1;
    end else begin
      if (wwin >= 0) m_wr_last = wwin;
      if (rwin >= 0) m_rd_last = rwin;
    end
  end

  // One cycle of stimulus; returns just after the falling edge
  task automatic drive(input bit r,
                       input bit ar, input bit aw, input int aa, input int ad,
                       input bit br, input bit bw, input int ba, input int bd);
    @(posedge clk);
    #1;
    rst = r;
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = 4'(aa); bus.a_wdata = 8'(ad);
    bus.b_req = br; bus.b_we = bw; bus.b_addr = 4'(ba); bus.b_wdata = 8'(bd);
    @(negedge clk);
    #1;
  endtask

  // Random-phase requester state
  bit cur_req [2];
  bit cur_we [2];
  int cur_addr [2];
  int cur_wdata [2];
  bit gnt_seen [2];
  int wait_cnt [2];

  initial begin
    bit rst_v;
    rst = 1'b1;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    // Reset with both requesting: nothing granted
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 1, 1, 8'h11, 1, 1, 2, 8'h22);
      chk("rst_a_gnt", int'(bus.a_gnt), 0);
      chk("rst_b_gnt", int'(bus.b_gnt), 0);
      chk("rst_ram_we", int'(bus.ram_we), 0);
    end
    $display("reset: gnt a=%0d b=%0d", bus.a_gnt, bus.b_gnt);

    // Contested writes alternate A,B,A,B starting with A
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 1, 8'h11, 1, 1, 2, 8'h22);
      chk("fair_a_gnt", int'(bus.a_gnt), (k % 2 == 0) ? 1 : 0);
      chk("fair_b_gnt", int'(bus.b_gnt), (k % 2 == 0) ? 0 : 1);
      chk("fair_ram_we", int'(bus.ram_we), 1);
      chk("fair_waddr", int'(bus.ram_write_addr), (k % 2 == 0) ? 1 : 2);
      $display("fair %0d: a_gnt=%0d b_gnt=%0d waddr=%0d", k, bus.a_gnt, bus.b_gnt, bus.ram_write_addr);
    end
    // A's last held write completes alone
    drive(0, 1, 1, 1, 8'h11, 0, 0, 0, 0);
    chk("hold_a_gnt", int'(bus.a_gnt), 1);

    // Single write then read
    drive(0, 1, 1, 3, 8'h5A, 0, 0, 0, 0);
    chk("wr3_a_gnt", int'(bus.a_gnt), 1);
    drive(0, 1, 0, 3, 0, 0, 0, 0, 0);
    chk("rd3_a_gnt", int'(bus.a_gnt), 1);
    chk("rd3_raddr", int'(bus.ram_read_addr), 3);
    chk("rd3_ram_we", int'(bus.ram_we), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd3_a_rvalid", int'(bus.a_rvalid), 1);
    chk("rd3_b_rvalid", int'(bus.b_rvalid), 0);
    chk("rd3_rdata", int'(bus.rdata), 8'h5A);
    $display("read addr3: rdata=0x%02h", bus.rdata);

    // Concurrent write and read on different requesters
    drive(0, 1, 1, 5, 8'h77, 1, 0, 2, 0);
    chk("conc_a_gnt", int'(bus.a_gnt), 1);
    chk("conc_b_gnt", int'(bus.b_gnt), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("conc_b_rvalid", int'(bus.b_rvalid), 1);
    chk("conc_rdata", int'(bus.rdata), 8'h22);
    $display("concurrent: b_rvalid=%0d rdata=0x%02h", bus.b_rvalid, bus.rdata);

    // Read/write collision on addr 4
    drive(0, 1, 1, 4, 8'h10, 0, 0, 0, 0);
    drive(0, 1, 1, 4, 8'h99, 1, 0, 4, 0);
    chk("coll_a_gnt", int'(bus.a_gnt), 1);
    chk("coll_b_gnt", int'(bus.b_gnt), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef RAM_PORT_ARBITER_BYPASS_EN
    chk("coll_rdata", int'(bus.rdata), 8'h99);
`else
    chk("coll_rdata", int'(bus.rdata), 8'h10);
`endif
    $display("collision: rdata=0x%02h", bus.rdata);
    drive(0, 0, 0, 0, 0, 1, 0, 4, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reread_rdata", int'(bus.rdata), 8'h99);

    // Reset right after a read grant
    drive(0, 0, 0, 0, 0, 1, 0, 4, 0);
    chk("rr_b_gnt", int'(bus.b_gnt), 1);
    drive(1, 1, 0, 6, 0, 1, 0, 7, 0);
    chk("rr_b_rvalid", int'(bus.b_rvalid), 1);
    chk("rr_rdata", int'(bus.rdata), 8'h99);
    chk("rr_a_gnt", int'(bus.a_gnt), 0);
    chk("rr_b_gnt0", int'(bus.b_gnt), 0);
    drive(0, 1, 0, 6, 0, 1, 0, 7, 0);
    chk("rr_post_a_gnt", int'(bus.a_gnt), 1);
    chk("rr_post_b_gnt", int'(bus.b_gnt), 0);
    $display("post-reset contested read: a_gnt=%0d b_gnt=%0d", bus.a_gnt, bus.b_gnt);
    drive(0, 0, 0, 0, 0, 1, 0, 7, 0);
    chk("rr_b_late_gnt", int'(bus.b_gnt), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 2; i++) begin
      cur_req[i] = 1'b0; gnt_seen[i] = 1'b0; wait_cnt[i] = 0;
      cur_we[i] = 1'b0; cur_addr[i] = 0; cur_wdata[i] = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst_v = ($urandom_range(0, 99) < 2);
      for (int i = 0; i < 2; i++) begin
        if (!cur_req[i] || gnt_seen[i]) begin
          if ($urandom_range(0, 99) < 70) begin
            cur_req[i] = 1'b1;
            cur_we[i] = 1'($urandom_range(0, 1));
            cur_addr[i] = int'($urandom_range(0, 7));
            cur_wdata[i] = int'($urandom_range(0, 255));
          end else begin
            cur_req[i] = 1'b0;
          end
        end
      end
      rst = rst_v;
      bus.a_req = cur_req[0]; bus.a_we = cur_we[0];
      bus.a_addr = 4'(cur_addr[0]); bus.a_wdata = 8'(cur_wdata[0]);
      bus.b_req = cur_req[1]; bus.b_we = cur_we[1];
      bus.b_addr = 4'(cur_addr[1]); bus.b_wdata = 8'(cur_wdata[1]);
      @(negedge clk);
      #1;
      gnt_seen[0] = bus.a_gnt;
      gnt_seen[1] = bus.b_gnt;
      for (int i = 0; i < 2; i++) begin
        if (rst_v || !cur_req[i] || gnt_seen[i]) begin
          wait_cnt[i] = 0;
        end else begin
          wait_cnt[i]++;
          chk("starvation_bound", int'(wait_cnt[i] <= 1), 1);
        end
      end
      if (n % 500 == 0)
        $display("random %0d: checks=%0d errors=%0d", n, checks, errors);
    end

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter sharing the `dual_port_RAM` (one write port, one registered read port) between two requesters, A and B. It sits between the switch/register front end (or any two masters) and the RAM. It arbitrates the write port and the read port independently, so one write and one read can complete in the same cycle. It tags the 1-cycle RAM read latency so returned data is steered to the requester that issued the read.

## Interface
- `DATA_WIDTH`, 8, RAM word width
- `ADDR_WIDTH`, 4, RAM address width

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `a_req`  in  1  requester A has an access pending; held until `a_gnt`
- `a_we`  in  1  A access type: 1 = write, 0 = read; stable while `a_req`
- `a_addr`  in  ADDR_WIDTH  A address
- `a_wdata`  in  DATA_WIDTH  A write data
- `a_gnt`  out  1  1-cycle pulse: A access issued to RAM this cycle
- `a_rvalid`  out  1  1-cycle pulse: `rdata` holds A's read result
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`: same as A, for requester B
- `rdata`  out  DATA_WIDTH  read result, shared by both requesters
- `ram_we`  out  1  to RAM `we`
- `ram_write_addr`  out  ADDR_WIDTH  to RAM `write_addr`
- `ram_read_addr`  out  ADDR_WIDTH  to RAM `read_addr`
- `ram_data_in`  out  DATA_WIDTH  to RAM `data_in`
- `ram_data_out`  in  DATA_WIDTH  from RAM `data_out`; registered read, valid 1 cycle after address

## Operation
- Two independent round-robin arbiters:
  - The write arbiter considers requesters with `req & we`.
  - The read arbiter considers requesters with `req & ~we`.
- Each arbiter has a 1-bit last-granted pointer (`wr_last`, `rd_last`).
  - When both requesters are eligible, the one not named by the pointer wins.
  - The pointer updates to the winner at the edge ending a grant cycle.
  - The pointer is unchanged when there is no grant.
- A requester has only one outstanding request type, so it cannot receive both grants in one cycle. A and B can be granted on different ports in the same cycle.
- Write grant in cycle T:
  - `ram_we`=1 in T.
  - `ram_write_addr` and `ram_data_in` come from the winner's addr/wdata.
  - The write is done at the end of T.
- Read grant in cycle T:
  - `ram_read_addr` is the winner's addr in T.
  - The winner ID is registered into `rd_tag`, and `rd_pend` is set.
- In T+1: `rdata`=`ram_data_out`, and the tagged `x_rvalid`=1 for exactly one cycle.
- Back-to-back reads are fully pipelined: one grant per cycle and one rvalid per cycle.
- When the read port is idle, `ram_read_addr` is 0. When the write port is idle, `ram_we`=0 and `ram_write_addr`/`ram_data_in` are 0.
- A requester may drop `req` or present a new request in the cycle after `gnt`.
- Changing `we`/`addr`/`wdata` while `req` is high and ungranted is illegal; behaviour in that case is unspecified.

## Timing
- Grant is combinational from `req` and the pointers. `gnt` and the RAM controls are valid in the same cycle as a qualifying `req`, with zero arbitration latency.
- Write latency is 0: the write commits at the edge closing the grant cycle. Read latency is 1: rvalid arrives the cycle after gnt.
- Reset, while `rst`=1:
  - `a_gnt`=`b_gnt`=0 and `ram_we`=0, regardless of `req`.
  - At the edge: `wr_last`=`rd_last`=B (so A has first priority), `rd_pend`=0, `rd_tag`=A.
  - In the cycle after reset: `a_rvalid`=`b_rvalid`=0. `rdata` equals `ram_data_out` (don't-care while rvalid=0).
- Reset mid-operation: if a read was granted in T and `rst`=1 in T+1, rvalid is still emitted in T+1, because it comes from state captured before reset. No new grants are issued while `rst`=1.
- Starvation bound: a continuously requesting requester is granted within 2 cycles on its port.
- Read-during-write, same address, same cycle: without the macro, `rdata` returns the pre-write (old) word.

## Configuration
- `RAM_PORT_ARBITER_BYPASS_EN`
  - Defined: when a read and a write are granted in the same cycle with `ram_read_addr`==`ram_write_addr`, the arbiter registers the write data and a match flag. In T+1, `rdata` = the new write data instead of `ram_data_out`.
  - Undefined: no forwarding logic; `rdata` is always `ram_data_out` (old data on collision).

## Test plan
- Reset then idle: `rst`=1 for 2 cycles with `a_req`=`b_req`=1 -> `a_gnt`=`b_gnt`=0 and `ram_we`=0. After release, first contested write goes to A.
- Single write then read: A writes 0x5A to addr 3. Next cycle A reads addr 3 -> `a_gnt` in the read cycle, then `a_rvalid`=1 and `rdata`=0x5A one cycle later, `b_rvalid`=0.
- Contention fairness: A and B both hold write requests for 4 cycles (A: addr 1/0x11, B: addr 2/0x22) -> grants A,B,A,B; `ram_we`=1 every cycle; RAM addr1=0x11, addr2=0x22.
- Concurrent ports: A writes 0x77 to addr 5 while B reads addr 2 (holding 0x22) -> both gnt in the same cycle; next cycle `b_rvalid`=1, `rdata`=0x22.
- Collision: addr 4 holds 0x10. In the same cycle A writes 0x99 to addr 4 and B reads addr 4 -> `rdata`=0x10 without the macro, 0x99 with `RAM_PORT_ARBITER_BYPASS_EN`. A later read of addr 4 returns 0x99 in both builds.
- Reset after read grant: B read granted in T, `rst`=1 in T+1 -> `b_rvalid`=1 in T+1. No gnt during reset. After release, contested read goes to A.
